// File: rtl/mem_pkg.sv
// Shared widths and state encoding for the burst memory controller.
package mem_pkg;
    localparam int MEM_DW = 8;
    localparam int MEM_AW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_rd_fifo.sv
// Two-entry read-data FIFO with valid/ready on both sides; accepts a push
// while full when the head is popped in the same cycle.
module mem_rd_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);
    logic [DW-1:0] slot [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          push;
    logic          pop;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = slot[rd_ptr];
    assign in_ready  = (cnt != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller: streams a block of memory words out (read) or writes an
// input stream into consecutive addresses (write), wrapping at the top.
//
//   state   | meaning
//   IDLE    | waiting for start; adr held, we low
//   RD      | issuing reads and draining the read FIFO until len words popped
//   WR      | accepting in_data words and writing them until len words stored
module mem_burst_ctrl
    import mem_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] adr,
    output logic          we,
    output logic [DW-1:0] dat_w,
    input  logic [DW-1:0] dat_r,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW:0]   issue_left;
    logic [AW:0]   words_left;
    logic          inflight_q;
    logic [1:0]    fifo_cnt;
    logic          fifo_in_ready;
    logic [2:0]    pending;
    logic          pop;
    logic          rd_issue;
    logic          wr_fire;

    mem_rd_fifo #(.DW(DW)) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_ready  (fifo_in_ready),
        .in_data   (dat_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (fifo_cnt)
    );

    // A word popped this cycle frees a slot for the read issued this cycle.
    assign pending  = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign pop      = out_valid && out_ready;
    assign rd_issue = (state == ST_RD) && (issue_left != '0) && ((pending < 3'd2) || pop);
    assign wr_fire  = (state == ST_WR) && in_valid;

    assign busy     = (state != ST_IDLE);
    assign adr      = addr_q;
    assign in_ready = (state == ST_WR);
    assign we       = wr_fire;
    assign dat_w    = (state == ST_WR) ? in_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            words_left <= '0;
            inflight_q <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            inflight_q <= rd_issue;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= mode ? ST_WR : ST_RD;
                            addr_q     <= base;
                            issue_left <= len;
                            words_left <= len;
                        end
                    end
                end
                ST_RD: begin
                    if (rd_issue) begin
                        addr_q     <= addr_q + AW'(1);
                        issue_left <= issue_left - (AW+1)'(1);
                    end
                    if (pop) begin
                        words_left <= words_left - (AW+1)'(1);
                        if (words_left == (AW+1)'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_fire) begin
                        addr_q     <= addr_q + AW'(1);
                        words_left <= words_left - (AW+1)'(1);
                        if (words_left == (AW+1)'(1)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a behavioural synchronous memory
// and a scoreboard of expected read words.
module tb_mem_burst_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, we, in_ready, out_valid;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w, out_data;
    logic [DW-1:0] dat_r = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b1;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] sb [$];
    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int ov_cnt = 0;

    mem_burst_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base(base), .len(len),
        .busy(busy), .done(done), .adr(adr), .we(we), .dat_w(dat_w), .dat_r(dat_r),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we) mem[adr] <= dat_w;
        dat_r <= mem[adr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Handshakes complete on the following posedge; inputs change only at negedge.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check_eq("rd_data", 32'(out_data), 32'(sb.pop_front()));
        end
        if (we) we_cnt++;
        if (done) done_cnt++;
        if (out_valid) ov_cnt++;
    end

    task automatic start_cmd(input logic m, input logic [AW-1:0] b, input logic [AW:0] l);
        @(negedge clk);
        start = 1'b1; mode = m; base = b; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit bp, input int budget);
        logic [3:0] pat = 4'b1001;
        int i = 0;
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bp) out_ready = (i < 4) ? pat[3-i] : 1'($urandom_range(0, 1));
            else    out_ready = 1'b1;
            i++;
            #3;
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_we"}, 32'(we), 32'd0);
        check_eq({tag, "_adr"}, 32'(adr), 32'd0);
        check_eq({tag, "_dat_w"}, 32'(dat_w), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int d0, w0, v0, k;
        logic [DW-1:0] wd [3];
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3 + 1);
        mem[0] = 8'h90; mem[1] = 8'hB3; mem[2] = 8'h23; mem[3] = 8'hFE;
        mem[14] = 8'h6E; mem[15] = 8'h98; mem[8] = 8'h55;

        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("rst");
        rst = 1'b0;

        // Straight read, checking first-word latency and back-to-back output.
        sb.push_back(8'h90); sb.push_back(8'hB3); sb.push_back(8'h23); sb.push_back(8'hFE);
        d0 = done_cnt;
        start_cmd(1'b0, 4'd0, 5'd4);
        #3;
        check_eq("rd_busy", 32'(busy), 32'd1);
        check_eq("rd_ov1", 32'(out_valid), 32'd0);
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            #3;
            if (i == 2) check_eq("rd_ov2", 32'(out_valid), 32'd0);
            else if (i <= 6) check_eq("rd_ov_stream", 32'(out_valid), 32'd1);
            else begin
                check_eq("rd_done", 32'(done), 32'd1);
                check_eq("rd_busy_fall", 32'(busy), 32'd0);
            end
        end
        @(negedge clk);
        #3;
        check_eq("rd_done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("rd_sb_empty", 32'(sb.size()), 32'd0);

        // Read wrapping past the top address.
        sb.push_back(8'h6E); sb.push_back(8'h98); sb.push_back(8'h90); sb.push_back(8'hB3);
        start_cmd(1'b0, 4'd14, 5'd4);
        run_until_done(1'b0, 30);
        check_eq("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Same read under out_ready backpressure.
        sb.push_back(8'h90); sb.push_back(8'hB3); sb.push_back(8'h23); sb.push_back(8'hFE);
        d0 = done_cnt;
        start_cmd(1'b0, 4'd0, 5'd4);
        run_until_done(1'b1, 200);
        @(negedge clk);
        check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("bp_done_once", 32'(done_cnt - d0), 32'd1);

        // Write burst with gaps; a start mid-burst must be ignored.
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
        d0 = done_cnt; w0 = we_cnt; v0 = ov_cnt;
        start_cmd(1'b1, 4'd5, 5'd3);
        k = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            start = (c == 2);
            mode = 1'b0; base = 4'd0; len = 5'd2;
            in_valid = (c % 2 == 1);
            in_data = wd[k];
            #2;
            if (in_valid && in_ready) k++;
        end
        check_eq("wr_accepted", 32'(k), 32'd3);
        run_until_done(1'b0, 10);
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("wr_mem5", 32'(mem[5]), 32'h11);
        check_eq("wr_mem6", 32'(mem[6]), 32'h22);
        check_eq("wr_mem7", 32'(mem[7]), 32'h33);
        check_eq("wr_mem8", 32'(mem[8]), 32'h55);
        check_eq("wr_we_count", 32'(we_cnt - w0), 32'd3);
        check_eq("wr_done_once", 32'(done_cnt - d0), 32'd1);
        check_eq("wr_no_ov", 32'(ov_cnt - v0), 32'd0);
        check_eq("wr_idle", 32'(busy), 32'd0);

        // Zero-length commands complete immediately without memory traffic.
        w0 = we_cnt; v0 = ov_cnt; d0 = done_cnt;
        start_cmd(1'b0, 4'd3, 5'd0);
        #3;
        check_eq("len0_done", 32'(done), 32'd1);
        check_eq("len0_busy", 32'(busy), 32'd0);
        start_cmd(1'b1, 4'd9, 5'd0);
        #3;
        check_eq("len0w_done", 32'(done), 32'd1);
        @(negedge clk);
        #3;
        check_eq("len0_done_pulse", 32'(done), 32'd0);
        check_eq("len0_done_count", 32'(done_cnt - d0), 32'd2);
        check_eq("len0_no_we", 32'(we_cnt - w0), 32'd0);
        check_eq("len0_no_ov", 32'(ov_cnt - v0), 32'd0);

        // Reset after two words of a six-word read.
        sb.push_back(8'h90); sb.push_back(8'hB3);
        start_cmd(1'b0, 4'd0, 5'd6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        #3;
        check_reset_outputs("abort");
        rst = 1'b0; out_ready = 1'b1;
        check_eq("abort_words", 32'(sb.size()), 32'd0);
        v0 = ov_cnt; w0 = we_cnt; d0 = done_cnt;
        repeat (10) @(negedge clk);
        #3;
        check_eq("abort_no_ov", 32'(ov_cnt - v0), 32'd0);
        check_eq("abort_no_we", 32'(we_cnt - w0), 32'd0);
        check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
